// File: rtl/alu_pkg.sv
// alu_pkg
// Shared encodings for the RISC-V ALU control path: the 2-bit ALUOp
// produced by the main decoder and the 3-bit ALU operation codes
// consumed by the execute-stage ALU.
package alu_pkg;

    // ALUOp values from the main decoder. Any ALUOp with bit 1 set is
    // treated as an ALU operation, so 2'b11 behaves like ALUOP_ALU.
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_ALU = 2'b10;

    // ALU operation codes. 3'b100, 3'b110 and 3'b111 are never produced.
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_code_e;

    // funct3 values recognised under an ALU operation.
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_ctrl_reg.sv
// alu_ctrl_reg
// ID/EX pipeline register for the ALU control word {illegal, ALUControl}.
// Priority on each rising edge: reset, then flush, then enable, else hold.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset (clears the word)
//   i_flush  synchronous clear, wins over i_en
//   i_en     capture enable; 0 holds the current word (stall)
//   i_d      control word to capture
//   o_q      registered control word
module alu_ctrl_reg (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_flush,
    input  logic       i_en,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    logic [3:0] r_q;

    // Stall/flush-aware capture of the decoded control word.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= 4'b0000;
        end else if (i_flush) begin
            r_q <= 4'b0000;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/alu_decoder.sv
// alu_decoder
// RISC-V ALU control decoder. Maps ALUOp, funct3, op5 and funct7[5] to a
// 3-bit ALU operation code, both combinationally for same-stage use and
// through a stall/flush-aware register for the ID/EX boundary.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset of the registered stage
//   op5          instruction bit 5 (1 = R-type, 0 = I-type ALU)
//   funct3       instruction funct3
//   funct7_5     instruction bit 30
//   ALUOp        main decoder op class: 00 mem, 01 branch, 1x ALU
//   en           register enable; 0 holds (stall)
//   flush        synchronous clear of the registered stage
//   ALUControl   combinational ALU operation
//   illegal      combinational: unsupported funct3 under an ALU op
//   ALUControlE  registered ALUControl
//   illegalE     registered illegal
module alu_decoder
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic [1:0] ALUOp,
    input  logic       en,
    input  logic       flush,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [2:0] ALUControlE,
    output logic       illegalE
);

    alu_code_e  w_ctrl;
    logic       w_illegal;
    logic [3:0] w_reg_q;

    // Decode. The instruction fields are only examined once ALUOp[1]
    // selects an ALU operation, so unknowns on them cannot leak into
    // the memory/branch results. op5 and funct7_5 matter only for
    // funct3=000, where an I-type with bit 30 set must still be ADD.
    always_comb begin
        w_ctrl    = ALU_ADD;
        w_illegal = 1'b0;
        if (ALUOp[1]) begin
            case (funct3)
                F3_ADDSUB: begin
                    if (op5 && funct7_5) begin
                        w_ctrl = ALU_SUB;
                    end else begin
                        w_ctrl = ALU_ADD;
                    end
                end
                F3_SLT:  w_ctrl = ALU_SLT;
                F3_OR:   w_ctrl = ALU_OR;
                F3_AND:  w_ctrl = ALU_AND;
                default: begin
                    // Shifts and xor/sltu are not supported by this ALU.
                    w_ctrl    = ALU_ADD;
                    w_illegal = 1'b1;
                end
            endcase
        end else if (ALUOp[0]) begin
            w_ctrl = ALU_SUB;
        end else begin
            w_ctrl = ALU_ADD;
        end
    end

    assign ALUControl = w_ctrl;
    assign illegal    = w_illegal;

    alu_ctrl_reg u_ctrl_reg (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_en    (en),
        .i_d     ({w_illegal, w_ctrl}),
        .o_q     (w_reg_q)
    );

    assign illegalE    = w_reg_q[3];
    assign ALUControlE = w_reg_q[2:0];

endmodule

// File: tb/tb_alu_decoder.sv
// tb_alu_decoder
// Scoreboard bench: each directed vector pushes its hand-computed
// combinational expectation and the expectation for the registered
// stage after the next edge; two monitors pop and compare.
module tb_alu_decoder;

    logic       clk;
    logic       rst_n;
    logic       op5;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [1:0] ALUOp;
    logic       en;
    logic       flush;
    logic [2:0] ALUControl;
    logic       illegal;
    logic [2:0] ALUControlE;
    logic       illegalE;

    int n_tests;
    int n_fail;

    logic [3:0] q_comb[$];
    string      q_comb_nm[$];
    logic [3:0] q_reg[$];
    string      q_reg_nm[$];

    alu_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op5         (op5),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .ALUOp       (ALUOp),
        .en          (en),
        .flush       (flush),
        .ALUControl  (ALUControl),
        .illegal     (illegal),
        .ALUControlE (ALUControlE),
        .illegalE    (illegalE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got {illegal,ctrl}=%b expected %b", nm, act, exp);
        end
    endtask

    // Apply one vector shortly after a rising edge and queue expectations.
    task automatic vec(input string nm, input logic [1:0] aop, input logic [2:0] f3,
                       input logic o5, input logic f7, input logic e, input logic fl,
                       input logic rn, input logic [2:0] exp_c, input logic exp_i,
                       input logic [2:0] exp_ce, input logic exp_ie);
        @(posedge clk);
        #2;
        ALUOp    = aop;
        funct3   = f3;
        op5      = o5;
        funct7_5 = f7;
        en       = e;
        flush    = fl;
        rst_n    = rn;
        q_comb.push_back({exp_i, exp_c});
        q_comb_nm.push_back({nm, "/comb"});
        q_reg.push_back({exp_ie, exp_ce});
        q_reg_nm.push_back({nm, "/reg"});
    endtask

    // Combinational monitor: mid-cycle, inputs have settled.
    always @(negedge clk) begin
        if (q_comb.size() > 0) begin
            check(q_comb_nm.pop_front(), {illegal, ALUControl}, q_comb.pop_front());
        end
    end

    // Registered monitor: just after the edge that followed the vector.
    always @(posedge clk) begin
        #1;
        if (q_reg.size() > 0) begin
            check(q_reg_nm.pop_front(), {illegalE, ALUControlE}, q_reg.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        flush    = 1'b0;
        ALUOp    = 2'b00;
        funct3   = 3'b000;
        op5      = 1'b0;
        funct7_5 = 1'b0;

        //   name        ALUOp  f3      op5   f7    en    fl    rst_n exp_c   i     exp_ce  ie
        vec("reset",     2'b00, 3'bxxx, 1'bx, 1'bx, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
        vec("mem_x",     2'b00, 3'bxxx, 1'bx, 1'bx, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0);
        vec("br_x",      2'b01, 3'bxxx, 1'bx, 1'bx, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 3'b001, 1'b0);
        vec("addi_b30",  2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0);
        vec("sub",       2'b10, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 3'b001, 1'b0);
        vec("add_r",     2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0);
        vec("slt_10",    2'b10, 3'b010, 1'bx, 1'bx, 1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 3'b101, 1'b0);
        vec("or_10",     2'b10, 3'b110, 1'bx, 1'bx, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 3'b011, 1'b0);
        vec("and_10",    2'b10, 3'b111, 1'bx, 1'bx, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 3'b010, 1'b0);
        vec("slt_11",    2'b11, 3'b010, 1'bx, 1'bx, 1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 3'b101, 1'b0);
        vec("or_11",     2'b11, 3'b110, 1'bx, 1'bx, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 3'b011, 1'b0);
        vec("and_11",    2'b11, 3'b111, 1'bx, 1'bx, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 3'b010, 1'b0);
        vec("sub_11",    2'b11, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 3'b001, 1'b0);
        vec("ill_001",   2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 1'b1);
        vec("ill_011",   2'b10, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 1'b1);
        vec("ill_100",   2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 1'b1);
        vec("ill_101",   2'b10, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 1'b1);
        vec("ill_11_001",2'b11, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 1'b1);
        vec("br_f3_ill", 2'b01, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 3'b001, 1'b0);
        // Registered-stage sequence.
        vec("rst_seq",   2'b10, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000, 1'b0);
        vec("cap_sub",   2'b10, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 3'b001, 1'b0);
        vec("hold_or",   2'b10, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 3'b001, 1'b0);
        vec("flush_en",  2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 3'b000, 1'b0);
        vec("cap_ill",   2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 1'b1);
        vec("hold_ill",  2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b1);
        vec("flush_noen",2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0, 3'b000, 1'b0);
        vec("cap_and",   2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 3'b010, 1'b0);
        vec("rst_mid",   2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 3'b000, 1'b0);
        vec("cap_ill2",  2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 1'b1);
        vec("rst_ill",   2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0);
        vec("cap_slt",   2'b11, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 3'b101, 1'b0);

        // Drain: both queues must empty within a few edges.
        repeat (3) @(posedge clk);
        #3;
        n_tests = n_tests + 1;
        if ((q_comb.size() != 0) || (q_reg.size() != 0)) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q_comb.size(), q_reg.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
